// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: Status/Cause/EPC/BadVAddr, event priority and a held fetch redirect.
// Define CP0_TIMER_EN to add the Count (#9) / Compare (#11) timer and Cause.TI.
module cp0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_over,
  input  logic        id_exception_flag,
  input  logic [1:0]  id_exception_type,
  input  logic        id_interrupt_flag,
  input  logic [1:0]  id_interrupt_type,
  input  logic        eret_executed,
  input  logic [31:0] ID_pc,
  input  logic [5:0]  irq,
  input  logic        cp0_wen,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic        redirect_ready,
  output logic        exc_flush,
  output logic        int_pending
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state;
  logic [7:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        ti;

  logic [7:0]  ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        sample;
  logic        take_exc;
  logic        take_int;
  logic        take_eret;
  logic [4:0]  entry_code;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_badvaddr;
  logic        unused_int_type;

  // The interrupt type is informational only; Int is the one defined encoding.
  assign unused_int_type = ^id_interrupt_type;

  // A pending timer interrupt overrides the sampled irq[5] on IP[15].
  assign ip         = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign status_val = {16'h0, im, 6'h0, exl, ie};
  assign cause_val  = {1'b0, ti, 14'h0, ip, 1'b0, exc_code, 2'b00};

  assign int_pending = (|(im & ip)) & ie & ~exl;

  assign sample    = (state == IDLE) && ID_over;
  assign take_exc  = sample && id_exception_flag;
  assign take_int  = sample && !id_exception_flag && id_interrupt_flag && int_pending;
  assign take_eret = sample && !id_exception_flag && !take_int && eret_executed;

  always_comb begin
    entry_code = 5'd0;
    if (id_exception_flag) begin
      case (id_exception_type)
        2'b00:   entry_code = 5'd4;
        2'b01:   entry_code = 5'd5;
        2'b10:   entry_code = 5'd10;
        default: entry_code = 5'd12;
      endcase
    end
  end

  assign wr_status   = cp0_wen && (cp0_waddr == 5'd12);
  assign wr_cause    = cp0_wen && (cp0_waddr == 5'd13);
  assign wr_epc      = cp0_wen && (cp0_waddr == 5'd14);
  assign wr_badvaddr = cp0_wen && (cp0_waddr == 5'd8);

  // MTC0 updates come first so that hardware entry/return updates below win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      im              <= 8'h0;
      exl             <= 1'b0;
      ie              <= 1'b0;
      ip_hw           <= 6'h0;
      ip_sw           <= 2'b00;
      exc_code        <= 5'd0;
      epc             <= 32'h0;
      badvaddr        <= 32'h0;
      redirect_valid  <= 1'b0;
      redirect_target <= 32'h0;
      exc_flush       <= 1'b0;
    end else begin
      ip_hw     <= irq;
      exc_flush <= 1'b0;
      if (wr_status) begin
        im  <= cp0_wdata[15:8];
        exl <= cp0_wdata[1];
        ie  <= cp0_wdata[0];
      end
      if (wr_cause) begin
        ip_sw    <= cp0_wdata[9:8];
        exc_code <= cp0_wdata[6:2];
      end
      if (wr_epc) epc <= cp0_wdata;
      if (wr_badvaddr) badvaddr <= cp0_wdata;

      case (state)
        IDLE: begin
          if (take_exc || take_int) begin
            exc_code <= entry_code;
            exl      <= 1'b1;
            if (!exl) epc <= ID_pc;
            if (take_exc && !id_exception_type[1]) badvaddr <= ID_pc;
            redirect_target <= EXC_VECTOR;
            redirect_valid  <= 1'b1;
            exc_flush       <= 1'b1;
            state           <= REDIRECT;
          end else if (take_eret) begin
            exl             <= 1'b0;
            redirect_target <= epc;
            redirect_valid  <= 1'b1;
            exc_flush       <= 1'b1;
            state           <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        half_tick;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = cp0_wen && (cp0_waddr == 5'd9);
  assign wr_compare = cp0_wen && (cp0_waddr == 5'd11);

  // Count advances on every other clock; a zero Compare never raises TI.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 32'h0;
      compare   <= 32'h0;
      half_tick <= 1'b0;
      ti        <= 1'b0;
    end else begin
      half_tick <= ~half_tick;
      if (wr_count) count <= cp0_wdata;
      else if (half_tick) count <= count + 32'd1;
      if (wr_compare) begin
        compare <= cp0_wdata;
        ti      <= 1'b0;
      end else if ((count == compare) && (compare != 32'h0)) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_raddr)
      5'd8:    cp0_rdata = badvaddr;
`ifdef CP0_TIMER_EN
      5'd9:    cp0_rdata = count;
      5'd11:   cp0_rdata = compare;
`endif
      5'd12:   cp0_rdata = status_val;
      5'd13:   cp0_rdata = cause_val;
      5'd14:   cp0_rdata = epc;
      default: cp0_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: directed scenarios plus randomized traffic against a CP0 model.
module tb_cp0_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_over;
  logic        id_exception_flag;
  logic [1:0]  id_exception_type;
  logic        id_interrupt_flag;
  logic [1:0]  id_interrupt_type;
  logic        eret_executed;
  logic [31:0] ID_pc;
  logic [5:0]  irq;
  logic        cp0_wen;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_ready;
  logic        exc_flush;
  logic        int_pending;

  int n_checks = 0;
  int n_errors = 0;

  cp0_exception_ctrl dut (
    .clk(clk), .reset(reset), .ID_over(ID_over),
    .id_exception_flag(id_exception_flag), .id_exception_type(id_exception_type),
    .id_interrupt_flag(id_interrupt_flag), .id_interrupt_type(id_interrupt_type),
    .eret_executed(eret_executed), .ID_pc(ID_pc), .irq(irq),
    .cp0_wen(cp0_wen), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .redirect_ready(redirect_ready), .exc_flush(exc_flush), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  // Architectural model of the CP0 state.
  logic [7:0]  m_im;
  logic        m_ie, m_exl;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_target;
  logic        m_busy, m_flush;
  logic [4:0]  codes [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

  function automatic logic m_pending();
    return ((m_im & {m_ip_hw, m_ip_sw}) != 8'h0) && m_ie && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {16'h0, m_ip_hw, m_ip_sw, 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: model consumes the current inputs, DUT outputs settle 1 ns after the edge.
  task automatic cycle();
    logic [7:0]  n_im = m_im;
    logic        n_ie = m_ie, n_exl = m_exl, n_busy = m_busy, n_flush = 1'b0;
    logic [5:0]  n_ip_hw = irq;
    logic [1:0]  n_ip_sw = m_ip_sw;
    logic [4:0]  n_code = m_code;
    logic [31:0] n_epc = m_epc, n_bad = m_bad, n_target = m_target;
    logic        is_int = id_interrupt_flag && m_pending();
    if (cp0_wen) begin
      if (cp0_waddr == 5'd12) begin n_im = cp0_wdata[15:8]; n_exl = cp0_wdata[1]; n_ie = cp0_wdata[0]; end
      if (cp0_waddr == 5'd13) begin n_ip_sw = cp0_wdata[9:8]; n_code = cp0_wdata[6:2]; end
      if (cp0_waddr == 5'd14) n_epc = cp0_wdata;
      if (cp0_waddr == 5'd8)  n_bad = cp0_wdata;
    end
    if (m_busy) begin
      if (redirect_ready) n_busy = 1'b0;
    end else if (ID_over && (id_exception_flag || is_int || eret_executed)) begin
      n_busy = 1'b1;
      n_flush = 1'b1;
      if (id_exception_flag || is_int) begin
        n_code = id_exception_flag ? codes[id_exception_type] : 5'd0;
        if (!m_exl) n_epc = ID_pc;
        n_exl = 1'b1;
        if (id_exception_flag && id_exception_type < 2'd2) n_bad = ID_pc;
        n_target = VEC;
      end else begin
        n_exl = 1'b0;
        n_target = m_epc;
      end
    end
    if (reset) begin
      n_im = 0; n_ie = 0; n_exl = 0; n_ip_hw = 0; n_ip_sw = 0; n_code = 0;
      n_epc = 0; n_bad = 0; n_target = 0; n_busy = 0; n_flush = 0;
    end
    @(posedge clk);
    #1;
    m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_ip_hw = n_ip_hw; m_ip_sw = n_ip_sw;
    m_code = n_code; m_epc = n_epc; m_bad = n_bad; m_target = n_target;
    m_busy = n_busy; m_flush = n_flush;
  endtask

  task automatic idle_inputs();
    reset = 0; ID_over = 0; id_exception_flag = 0; id_exception_type = 0;
    id_interrupt_flag = 0; id_interrupt_type = 2'b01; eret_executed = 0;
    ID_pc = 0; irq = 0; cp0_wen = 0; cp0_waddr = 0; cp0_wdata = 0;
    cp0_raddr = 0; redirect_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_raddr = a;
    #1;
    v = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_wen = 1; cp0_waddr = a; cp0_wdata = d;
    cycle();
    cp0_wen = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    n_checks++;
    if ({redirect_valid, exc_flush, int_pending} !== 3'b000) begin
      n_errors++; $display("FAIL reset_outputs: got %b exp 000", {redirect_valid, exc_flush, int_pending});
    end
    for (int a = 8; a <= 14; a++) begin
      rd(a[4:0], v);
      n_checks++;
      if (v !== 32'h0) begin n_errors++; $display("FAIL reset_reg%0d: got %h exp 0", a, v); end
    end
    $display("reset: done");
  endtask

  task automatic test_ri();
    logic [31:0] v;
    do_reset();
    ID_over = 1; id_exception_flag = 1; id_exception_type = 2'b10; ID_pc = 32'h40;
    cycle();
    idle_inputs();
    n_checks++;
    if ({redirect_valid, exc_flush} !== 2'b11 || redirect_target !== VEC) begin
      n_errors++; $display("FAIL ri_redirect: got v=%b f=%b t=%h exp v=1 f=1 t=%h", redirect_valid, exc_flush, redirect_target, VEC);
    end
    rd(5'd14, v);
    n_checks++;
    if (v !== 32'h40) begin n_errors++; $display("FAIL ri_epc: got %h exp 40", v); end
    rd(5'd13, v);
    n_checks++;
    if (v[6:2] !== 5'd10) begin n_errors++; $display("FAIL ri_exccode: got %0d exp 10", v[6:2]); end
    rd(5'd12, v);
    n_checks++;
    if (v[1] !== 1'b1) begin n_errors++; $display("FAIL ri_exl: got %b exp 1", v[1]); end
    redirect_ready = 1;
    cycle();
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL ri_release: got %b exp 0", redirect_valid); end
    $display("ri: pc=40 target=%h", VEC);
  endtask

  task automatic test_adel_nested();
    logic [31:0] v;
    do_reset();
    ID_over = 1; id_exception_flag = 1; id_exception_type = 2'b00; ID_pc = 32'h42;
    cycle();
    idle_inputs(); redirect_ready = 1;
    cycle();
    rd(5'd8, v);
    n_checks++;
    if (v !== 32'h42) begin n_errors++; $display("FAIL adel_badvaddr: got %h exp 42", v); end
    rd(5'd13, v);
    n_checks++;
    if (v[6:2] !== 5'd4) begin n_errors++; $display("FAIL adel_exccode: got %0d exp 4", v[6:2]); end
    idle_inputs();
    ID_over = 1; id_exception_flag = 1; id_exception_type = 2'b10; ID_pc = 32'h80;
    cycle();
    idle_inputs();
    rd(5'd14, v);
    n_checks++;
    if (v !== 32'h42 || redirect_valid !== 1'b1) begin
      n_errors++; $display("FAIL nested_epc: got epc=%h v=%b exp epc=42 v=1", v, redirect_valid);
    end
    redirect_ready = 1;
    cycle();
    $display("adel_nested: epc kept at 42");
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    do_reset();
    irq = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    n_checks++;
    if (int_pending !== 1'b1) begin n_errors++; $display("FAIL int_pending: got %b exp 1", int_pending); end
    ID_over = 1; id_interrupt_flag = 1; ID_pc = 32'h200;
    cycle();
    ID_over = 0; id_interrupt_flag = 0;
    rd(5'd13, v);
    n_checks++;
    if (redirect_valid !== 1'b1 || v[6:2] !== 5'd0 || v[10] !== 1'b1) begin
      n_errors++; $display("FAIL int_entry: got v=%b cause=%h exp v=1 code=0 ip2=1", redirect_valid, v);
    end
    rd(5'd14, v);
    n_checks++;
    if (v !== 32'h200) begin n_errors++; $display("FAIL int_epc: got %h exp 200", v); end
    do_reset();
    irq = 6'b000001;
    mtc0(5'd12, 32'h0000_0400);
    ID_over = 1; id_interrupt_flag = 1; ID_pc = 32'h300;
    cycle();
    idle_inputs();
    n_checks++;
    if ({redirect_valid, exc_flush, int_pending} !== 3'b000) begin
      n_errors++; $display("FAIL int_masked: got %b exp 000", {redirect_valid, exc_flush, int_pending});
    end
    $display("interrupt: taken with IE=1, ignored with IE=0");
  endtask

  task automatic test_eret_hold();
    logic [31:0] v;
    do_reset();
    mtc0(5'd14, 32'h100);
    mtc0(5'd12, 32'h2);
    ID_over = 1; eret_executed = 1;
    cycle();
    idle_inputs();
    rd(5'd12, v);
    n_checks++;
    if ({redirect_valid, exc_flush} !== 2'b11 || redirect_target !== 32'h100 || v[1] !== 1'b0) begin
      n_errors++; $display("FAIL eret: got v=%b f=%b t=%h exl=%b exp 1 1 100 0", redirect_valid, exc_flush, redirect_target, v[1]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({redirect_valid, exc_flush} !== 2'b10 || redirect_target !== 32'h100) begin
        n_errors++; $display("FAIL eret_hold%0d: got v=%b f=%b t=%h exp 1 0 100", i, redirect_valid, exc_flush, redirect_target);
      end
    end
    redirect_ready = 1;
    cycle();
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_errors++; $display("FAIL eret_release: got %b exp 0", redirect_valid); end
    $display("eret_hold: target 100 held 3 cycles");
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    do_reset();
    ID_over = 1; id_exception_flag = 1; id_exception_type = 2'b11; eret_executed = 1; ID_pc = 32'h20;
    cp0_wen = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h55;
    cycle();
    idle_inputs();
    rd(5'd14, v);
    n_checks++;
    if (v !== 32'h20 || redirect_target !== VEC) begin
      n_errors++; $display("FAIL same_epc: got epc=%h t=%h exp 20 %h", v, redirect_target, VEC);
    end
    rd(5'd12, v);
    n_checks++;
    if (v[1] !== 1'b1) begin n_errors++; $display("FAIL same_exl: got %b exp 1", v[1]); end
    rd(5'd13, v);
    n_checks++;
    if (v[6:2] !== 5'd12) begin n_errors++; $display("FAIL same_code: got %0d exp 12", v[6:2]); end
    $display("same_cycle: exception wins");
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    ID_over = 1; id_exception_flag = 1; id_exception_type = 2'b10; ID_pc = 32'h60;
    cycle();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
    n_checks++;
    if ({redirect_valid, exc_flush} !== 2'b00) begin
      n_errors++; $display("FAIL reset_redirect: got %b exp 00", {redirect_valid, exc_flush});
    end
    cycle();
    n_checks++;
    if ({redirect_valid, exc_flush} !== 2'b00) begin
      n_errors++; $display("FAIL reset_redirect_after: got %b exp 00", {redirect_valid, exc_flush});
    end
    $display("reset_in_redirect: outputs cleared");
  endtask

  task automatic test_timer();
    logic [31:0] v;
    do_reset();
`ifdef CP0_TIMER_EN
    begin
      bit seen = 0;
      mtc0(5'd11, 32'd10);
      for (int i = 0; i < 60 && !seen; i++) begin
        cycle();
        rd(5'd13, v);
        seen = v[30];
      end
      n_checks++;
      if (!seen || v[15] !== 1'b1) begin n_errors++; $display("FAIL timer_ti: got ti=%b ip7=%b exp 1 1", seen, v[15]); end
      rd(5'd9, v);
      n_checks++;
      if (v < 32'd10 || v > 32'd12) begin n_errors++; $display("FAIL timer_count: got %0d exp 10..12", v); end
      mtc0(5'd11, 32'd0);
      rd(5'd13, v);
      n_checks++;
      if (v[30] !== 1'b0) begin n_errors++; $display("FAIL timer_clear: got %b exp 0", v[30]); end
    end
`else
    mtc0(5'd9, 32'h1234);
    mtc0(5'd11, 32'h5678);
    rd(5'd9, v);
    n_checks++;
    if (v !== 32'h0) begin n_errors++; $display("FAIL no_timer_count: got %h exp 0", v); end
    rd(5'd11, v);
    n_checks++;
    if (v !== 32'h0) begin n_errors++; $display("FAIL no_timer_compare: got %h exp 0", v); end
`endif
    $display("timer: done");
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [4:0]  wtab [5] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd3};
    logic [4:0]  a;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ID_over = $urandom_range(0, 1);
      id_exception_flag = ($urandom_range(0, 3) == 0);
      id_exception_type = 2'($urandom);
      id_interrupt_flag = $urandom_range(0, 1);
      eret_executed = ($urandom_range(0, 3) == 0);
      ID_pc = $urandom;
      irq = 6'($urandom);
      cp0_wen = ($urandom_range(0, 3) == 0);
      cp0_waddr = wtab[$urandom_range(0, 4)];
      cp0_wdata = $urandom;
      redirect_ready = $urandom_range(0, 1);
      reset = ($urandom_range(0, 63) == 0);
      cycle();
      n_checks++;
      if (redirect_valid !== m_busy || exc_flush !== m_flush || int_pending !== m_pending() ||
          (m_busy && redirect_target !== m_target)) begin
        n_errors++;
        $display("FAIL rand_out%0d: got v=%b f=%b p=%b t=%h exp v=%b f=%b p=%b t=%h", i,
                 redirect_valid, exc_flush, int_pending, redirect_target, m_busy, m_flush, m_pending(), m_target);
      end
      a = 5'($urandom_range(0, 31));
      if (a == 5'd9 || a == 5'd11) a = 5'd13;
      rd(a, v);
      n_checks++;
      if (v !== m_read(a)) begin n_errors++; $display("FAIL rand_rd%0d: reg %0d got %h exp %h", i, a, v, m_read(a)); end
    end
    idle_inputs();
    $display("random: 800 cycles");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_ri();
    test_adel_nested();
    test_interrupt();
    test_eret_hold();
    test_same_cycle();
    test_reset_in_redirect();
    test_timer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
